// File: rtl/opacc_pkg.sv
// Shared types for the opacc command sequencer: command opcodes, FSM states,
// and a small helper for sizing counters.
package opacc_pkg;

    typedef enum logic [1:0] {
        OP_LOADC  = 2'b00,
        OP_MAC    = 2'b01,
        OP_STOREC = 2'b10,
        OP_RSVD   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_LOAD  = 2'b01,
        S_MAC   = 2'b10,
        S_STORE = 2'b11
    } state_e;

    // Larger of two integers, used to size the beat counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/opacc_skid.sv
// opacc_skid: two-entry registered valid/ready buffer. The head entry drives
// the output directly from a register; the tail entry absorbs one extra beat so
// the producer can keep going for one cycle after the consumer stalls.
module opacc_skid
    import opacc_pkg::*;
#(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             push;
    logic             pop;

    // A full buffer still accepts a beat in a cycle where the head leaves.
    assign in_ready_o  = (count_q != 2'd2) || out_ready_i;
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = head_q;
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    // Next-state for head/tail/count, keeping strict FIFO order.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = in_data_i;
                end else begin
                    tail_d = in_data_i;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_d = in_data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = in_data_i;
                end
            end
            default: begin
            end
        endcase
    end

    // Buffer registers; reset flushes both entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/opacc_seq.sv
// opacc_seq: command sequencer in front of opacc. Runs one LOADC/MAC/STOREC
// command at a time, steers the data stream into opacc's ci / ai,bj ports and
// drains stored C rows through a registered two-entry output buffer.
//
// Handshakes: every stream (cmd, din, dout) transfers exactly on a rising clock
// edge where valid && ready; valid never depends on ready from the same stream,
// while ready may depend on valid-independent state (and, for the STORE shift,
// on dout_ready through the buffer).
module opacc_seq
    import opacc_pkg::*;
#(
    parameter int nregs = 2,
    parameter int XLEN  = 8,
    parameter int vl    = 4,
    parameter int ml    = 4,
    parameter int LENW  = 8,
    localparam int AW   = (nregs > 1) ? $clog2(nregs) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [AW-1:0]      cmd_addr,
    input  logic [LENW-1:0]    cmd_len,
    input  logic               din_valid,
    output logic               din_ready,
    input  logic [ml*XLEN-1:0] din_a,
    input  logic [vl*XLEN-1:0] din_b,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic [vl*XLEN-1:0] dout_row,
    output logic               dout_last,
    output logic               busy,
    output logic               ci_valid,
    output logic               ab_valid,
    output logic [AW-1:0]      cld_addr,
    output logic [AW-1:0]      cst_addr,
    output logic [AW-1:0]      ab_addr,
    output logic [ml*XLEN-1:0] ai,
    output logic [vl*XLEN-1:0] bj,
    output logic [vl*XLEN-1:0] ci,
    input  logic [vl*XLEN-1:0] co
);

    localparam int RW = vl * XLEN;
    localparam int CW = max_int($clog2(ml + 1), LENW + 1);
    localparam logic [CW-1:0] ML_LAST = CW'(ml - 1);

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [LENW-1:0] len_q, len_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   mac_last;

    logic            skid_push;
    logic            skid_last;
    logic            skid_in_ready;
    logic            skid_valid;
    logic [RW:0]     skid_data;

    assign mac_last = {{(CW - LENW){1'b0}}, len_q};

    // Next-state and opacc drive; every output defaults to idle values and
    // everything is held quiet while reset is asserted.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        cmd_ready = 1'b0;
        din_ready = 1'b0;
        ci_valid  = 1'b0;
        ab_valid  = 1'b0;
        cld_addr  = '0;
        cst_addr  = '0;
        ab_addr   = '0;
        ai        = '0;
        bj        = '0;
        ci        = '0;
        skid_push = 1'b0;
        skid_last = 1'b0;
        if (!reset) begin
            case (state_q)
                S_IDLE: begin
                    cmd_ready = 1'b1;
                    if (cmd_valid) begin
                        addr_d = cmd_addr;
                        len_d  = cmd_len;
                        cnt_d  = '0;
                        case (op_e'(cmd_op))
                            OP_LOADC:  state_d = S_LOAD;
                            OP_MAC:    state_d = S_MAC;
                            OP_STOREC: state_d = S_STORE;
                            default:   state_d = S_IDLE;
                        endcase
                    end
                end
                S_LOAD: begin
                    din_ready = 1'b1;
                    cld_addr  = addr_q;
                    if (din_valid) begin
                        ci_valid = 1'b1;
                        ci       = din_b;
                        if (cnt_q == ML_LAST) begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                S_MAC: begin
                    din_ready = 1'b1;
                    ab_addr   = addr_q;
                    if (din_valid) begin
                        ab_valid = 1'b1;
                        ai       = din_a;
                        bj       = din_b;
                        if (cnt_q == mac_last) begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                S_STORE: begin
                    // Bottom row leaves on co while zeros shift in, so the
                    // drain also clears the bank.
                    cld_addr = addr_q;
                    cst_addr = addr_q;
                    if (skid_in_ready) begin
                        ci_valid  = 1'b1;
                        skid_push = 1'b1;
                        skid_last = (cnt_q == ML_LAST);
                        if (cnt_q == ML_LAST) begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Command state registers; reset aborts any command in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    opacc_skid #(
        .WIDTH(RW + 1)
    ) u_skid (
        .clk        (clk),
        .reset      (reset),
        .in_valid_i (skid_push),
        .in_ready_o (skid_in_ready),
        .in_data_i  ({skid_last, co}),
        .out_valid_o(skid_valid),
        .out_ready_i(dout_ready),
        .out_data_o (skid_data)
    );

    assign dout_valid = skid_valid && !reset;
    assign dout_row   = reset ? '0 : skid_data[RW-1:0];
    assign dout_last  = skid_data[RW] && skid_valid && !reset;
    assign busy       = !reset && ((state_q != S_IDLE) || skid_valid);

endmodule

// File: tb/tb_opacc_seq.sv
// Bench for opacc_seq with a behavioural opacc accumulator array attached.
module tb_opacc_seq;
    import opacc_pkg::*;

    localparam int NREGS = 2;
    localparam int XLEN  = 8;
    localparam int VL    = 4;
    localparam int ML    = 4;
    localparam int LENW  = 8;
    localparam int RW    = VL * XLEN;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic            cmd_valid, cmd_ready;
    logic [1:0]      cmd_op;
    logic            cmd_addr;
    logic [LENW-1:0] cmd_len;
    logic            din_valid, din_ready;
    logic [RW-1:0]   din_a, din_b;
    logic            dout_valid, dout_ready, dout_last, busy;
    logic [RW-1:0]   dout_row;
    logic            ci_valid, ab_valid;
    logic            cld_addr, cst_addr, ab_addr;
    logic [RW-1:0]   ai, bj, ci, co;

    opacc_seq #(
        .nregs(NREGS), .XLEN(XLEN), .vl(VL), .ml(ML), .LENW(LENW)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .din_valid(din_valid), .din_ready(din_ready), .din_a(din_a), .din_b(din_b),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_row(dout_row),
        .dout_last(dout_last), .busy(busy),
        .ci_valid(ci_valid), .ab_valid(ab_valid),
        .cld_addr(cld_addr), .cst_addr(cst_addr), .ab_addr(ab_addr),
        .ai(ai), .bj(bj), .ci(ci), .co(co)
    );

    // ---------------- opacc model ----------------
    // ci enters row 0 and shifts toward row ML-1; co is row ML-1 of cst_addr.
    logic [XLEN-1:0] cio [NREGS][ML][VL];

    initial begin
        for (int b = 0; b < NREGS; b++)
            for (int r = 0; r < ML; r++)
                for (int j = 0; j < VL; j++)
                    cio[b][r][j] = '0;
    end

    always @(posedge clk) begin
        if (ci_valid) begin
            for (int r = ML - 1; r > 0; r--) cio[cld_addr][r] <= cio[cld_addr][r-1];
            for (int j = 0; j < VL; j++) cio[cld_addr][0][j] <= ci[j*XLEN +: XLEN];
        end
        if (ab_valid) begin
            for (int i = 0; i < ML; i++)
                for (int j = 0; j < VL; j++)
                    cio[ab_addr][i][j] <= XLEN'(cio[ab_addr][i][j] +
                        XLEN'(ai[i*XLEN +: XLEN] * bj[j*XLEN +: XLEN]));
        end
    end

    always_comb begin
        co = '0;
        for (int j = 0; j < VL; j++) co[j*XLEN +: XLEN] = cio[cst_addr][ML-1][j];
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    int ci_pulses = 0;
    logic [RW:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (ci_valid) ci_pulses++;
            if (ci_valid || ab_valid) check("ci_ab_exclusive", 64'(ci_valid & ab_valid), 64'd0);
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dout_unexpected: got %h last %b expected none", dout_row, dout_last);
                end else begin
                    check("dout_row_last", 64'({dout_last, dout_row}), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic a, input logic [LENW-1:0] len);
        int n;
        bit done;
        n = 0;
        done = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_len = len;
        while (!done) begin
            @(negedge clk);
            if (cmd_ready) done = 1;
            else if (++n > 200) begin
                checks++; errors++; done = 1;
                $display("FAIL cmd_timeout: cmd_ready stayed %b, required 1", cmd_ready);
            end
            tick();
        end
        cmd_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [RW-1:0] a, input logic [RW-1:0] b);
        int n;
        bit done;
        n = 0;
        done = 0;
        din_valid = 1'b1; din_a = a; din_b = b;
        while (!done) begin
            @(negedge clk);
            if (din_ready) done = 1;
            else if (++n > 200) begin
                checks++; errors++; done = 1;
                $display("FAIL din_timeout: din_ready stayed %b, required 1", din_ready);
            end
            tick();
        end
        din_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy) && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (n >= 500) begin
            checks++; errors++;
            $display("FAIL drain_timeout: busy %b pending %0d, required 0 and 0", busy, exp_q.size());
        end
        tick();
    endtask

    task automatic push_exp(input logic [RW-1:0] row, input logic last);
        exp_q.push_back({last, row});
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [RW-1:0] din_b;
        logic [RW-1:0] exp_row;
        logic          exp_last;
    } vec_t;

    vec_t tbl [4];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [RW-1:0] va, vb, vr;

        // r_i[j] = i*4+j, element j in the low byte upward
        tbl[0] = '{32'h03020100, 32'h03020100, 1'b0};
        tbl[1] = '{32'h07060504, 32'h07060504, 1'b0};
        tbl[2] = '{32'h0b0a0908, 32'h0b0a0908, 1'b0};
        tbl[3] = '{32'h0f0e0d0c, 32'h0f0e0d0c, 1'b1};

        cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_len = 0;
        din_valid = 0; din_a = 0; din_b = 0; dout_ready = 1;

        // 1: reset
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 0);
        check("rst_din_ready", 64'(din_ready), 0);
        check("rst_dout", 64'({dout_valid, dout_last, dout_row}), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_valids", 64'({ci_valid, ab_valid}), 0);
        check("rst_addrs", 64'({cld_addr, cst_addr, ab_addr}), 0);
        check("rst_ai_bj", 64'({ai, bj}), 0);
        check("rst_ci", 64'(ci), 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_ready", 64'(cmd_ready), 1);
        check("post_rst_busy", 64'(busy), 0);
        tick();

        // reserved op is accepted and stays idle
        send_cmd(2'b11, 1'b0, 8'd0);
        @(negedge clk);
        check("rsvd_busy", 64'(busy), 0);
        check("rsvd_cmd_ready", 64'(cmd_ready), 1);
        check("idle_din_ready", 64'(din_ready), 0);
        tick();

        // 2: LOADC bank0 from table, STOREC in order, then second STOREC zeros
        send_cmd(OP_LOADC, 1'b0, 8'd0);
        for (int i = 0; i < 4; i++) send_beat('0, tbl[i].din_b);
        for (int i = 0; i < 4; i++) push_exp(tbl[i].exp_row, tbl[i].exp_last);
        send_cmd(OP_STOREC, 1'b0, 8'd0);
        wait_drain();
        for (int i = 0; i < 4; i++) push_exp('0, i == 3);
        send_cmd(OP_STOREC, 1'b0, 8'd0);
        wait_drain();

        // 3: LOADC zeros bank1, MAC len=3, STOREC -> rows 3..0, C[i][j]=14*i*j
        send_cmd(OP_LOADC, 1'b1, 8'd0);
        for (int i = 0; i < 4; i++) send_beat('0, '0);
        send_cmd(OP_MAC, 1'b1, 8'd3);
        for (int k = 0; k < 4; k++) begin
            for (int e = 0; e < 4; e++) begin
                va[e*XLEN +: XLEN] = XLEN'(e * k);
                vb[e*XLEN +: XLEN] = XLEN'(e * k);
            end
            send_beat(va, vb);
        end
        for (int i = 3; i >= 0; i--) begin
            for (int j = 0; j < 4; j++) vr[j*XLEN +: XLEN] = XLEN'(14 * i * j);
            push_exp(vr, i == 0);
        end
        send_cmd(OP_STOREC, 1'b1, 8'd0);
        wait_drain();

        // 4: STOREC under backpressure: two shifts, stall, then the rest
        send_cmd(OP_LOADC, 1'b0, 8'd0);
        for (int i = 0; i < 4; i++) send_beat('0, tbl[i].din_b);
        for (int i = 0; i < 4; i++) push_exp(tbl[i].exp_row, tbl[i].exp_last);
        dout_ready = 1'b0;
        ci_pulses = 0;
        send_cmd(OP_STOREC, 1'b0, 8'd0);
        repeat (10) tick();
        @(negedge clk);
        check("bp_shifts", 64'(ci_pulses), 2);
        check("bp_dout_valid", 64'(dout_valid), 1);
        check("bp_busy", 64'(busy), 1);
        tick();
        dout_ready = 1'b1;
        wait_drain();
        check("bp_total_shifts", 64'(ci_pulses), 4);

        // 5: cross-bank isolation
        send_cmd(OP_LOADC, 1'b0, 8'd0);
        for (int i = 0; i < 4; i++) send_beat('0, 32'h11111111);
        send_cmd(OP_MAC, 1'b1, 8'd0);
        send_beat(32'h01010101, 32'h02020202);
        for (int i = 0; i < 4; i++) push_exp(32'h11111111, i == 3);
        send_cmd(OP_STOREC, 1'b0, 8'd0);
        wait_drain();
        for (int i = 0; i < 4; i++) push_exp(32'h02020202, i == 3);
        send_cmd(OP_STOREC, 1'b1, 8'd0);
        wait_drain();

        // 6: reset in the middle of a STOREC
        send_cmd(OP_LOADC, 1'b0, 8'd0);
        for (int i = 0; i < 4; i++) send_beat('0, tbl[i].din_b);
        dout_ready = 1'b0;
        ci_pulses = 0;
        send_cmd(OP_STOREC, 1'b0, 8'd0);
        repeat (4) tick();
        @(negedge clk);
        check("mid_store_shifts", 64'(ci_pulses), 2);
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_cmd_ready", 64'(cmd_ready), 0);
        check("mid_rst_ci_valid", 64'(ci_valid), 0);
        tick();
        reset = 1'b0;
        dout_ready = 1'b1;
        @(negedge clk);
        check("after_rst_dout_valid", 64'(dout_valid), 0);
        check("after_rst_busy", 64'(busy), 0);
        check("after_rst_cmd_ready", 64'(cmd_ready), 1);
        tick();
        send_cmd(OP_LOADC, 1'b1, 8'd0);
        for (int i = 0; i < 4; i++) send_beat('0, tbl[i].din_b);
        for (int i = 0; i < 4; i++) push_exp(tbl[i].exp_row, tbl[i].exp_last);
        send_cmd(OP_STOREC, 1'b1, 8'd0);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
